sifh_frame_sequencer: RTL and testbench

SIFH_FRAME_SEQUENCER -- requirements
Module: sifh_frame_sequencer

---
 rtl/sifh_frame_sequencer.sv | 133 +++++++++++++
 tb/tb_sifh_frame_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sifh_frame_sequencer.sv
// sifh_frame_sequencer: feeds per-pixel timestamps to a histogram builder in a coarse then a fine pass,
// inserting an all-ones null word whenever the current pixel stays silent for TIMEOUT cycles.
module sifh_frame_sequencer #(
   parameter int PIXEL_NUM = 4,
   parameter int DATA_NUM  = 4,
   parameter int ACQ_NUM   = 8,
   parameter int NP        = 16,
   parameter int TIMEOUT   = 15,
   parameter int GAP       = 4
) (
   input  logic                    clk,
   input  logic                    res,
   input  logic                    start,
   input  logic                    abort,
   input  logic [PIXEL_NUM-1:0]    src_valid,
   input  logic [PIXEL_NUM*NP-1:0] src_data,
   output logic [PIXEL_NUM-1:0]    src_ready,
   output logic                    wr_en,
   output logic [NP-1:0]           data,
   output logic                    pass,
   output logic                    busy,
   output logic                    frame_done,
   output logic [15:0]             null_cnt
);
   localparam int SW = DATA_NUM > 1 ? $clog2(DATA_NUM) : 1;
   localparam int PW = PIXEL_NUM > 1 ? $clog2(PIXEL_NUM) : 1;
   localparam int AW = ACQ_NUM > 1 ? $clog2(ACQ_NUM) : 1;
   localparam int WW = $clog2((TIMEOUT > GAP ? TIMEOUT : GAP) + 1);

   typedef enum logic [1:0] {IDLE, FEED, GAP_WAIT, DONE} state_t;

   state_t          state_q, state_d;
   logic [SW-1:0]   slot_q, slot_d;
   logic [PW-1:0]   pix_q, pix_d;
   logic [AW-1:0]   acq_q, acq_d;
   logic [WW-1:0]   wait_q, wait_d;
   logic            pass_q, pass_d, wr_en_q, wr_en_d;
   logic [NP-1:0]   data_q, data_d;
   logic [15:0]     null_q, null_d;
   logic            hs, to, last_slot, last_pix, last_acq;

   assign src_ready  = state_q == FEED ? PIXEL_NUM'(1) << pix_q : '0;
   assign busy       = state_q != IDLE;
   assign frame_done = state_q == DONE;
   assign wr_en      = wr_en_q;
   assign data       = data_q;
   assign pass       = pass_q;
   assign null_cnt   = null_q;

   // a handshake on the timeout cycle takes precedence, so the word is never counted twice
   assign hs        = state_q == FEED && src_valid[pix_q];
   assign to        = state_q == FEED && !hs && wait_q == WW'(TIMEOUT);
   assign last_slot = slot_q == SW'(DATA_NUM - 1);
   assign last_pix  = pix_q == PW'(PIXEL_NUM - 1);
   assign last_acq  = acq_q == AW'(ACQ_NUM - 1);

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      pix_d   = pix_q;
      acq_d   = acq_q;
      wait_d  = wait_q;
      pass_d  = pass_q;
      wr_en_d = 1'b0;
      data_d  = data_q;
      null_d  = null_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = FEED;
            slot_d  = '0;
            pix_d   = '0;
            acq_d   = '0;
            wait_d  = '0;
            pass_d  = 1'b0;
            null_d  = '0;
         end
         FEED: if (hs || to) begin
            wr_en_d = 1'b1;
            data_d  = hs ? src_data[int'(pix_q)*NP +: NP] : '1;
            null_d  = to ? null_q + 16'(null_q != 16'hFFFF) : null_q;
            wait_d  = '0;
            slot_d  = last_slot ? '0 : slot_q + SW'(1);
            pix_d   = last_slot ? (last_pix ? '0 : pix_q + PW'(1)) : pix_q;
            acq_d   = last_slot && last_pix ? (last_acq ? '0 : acq_q + AW'(1)) : acq_q;
            if (last_slot && last_pix && last_acq) state_d = pass_q ? DONE : GAP_WAIT;
         end else begin
            wait_d = wait_q + WW'(1);
         end
         GAP_WAIT: begin
            wait_d = wait_q + WW'(1);
            if (wait_q == WW'(GAP - 1)) begin
               state_d = FEED;
               pass_d  = 1'b1;
               slot_d  = '0;
               pix_d   = '0;
               acq_d   = '0;
               wait_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d = IDLE;
         wr_en_d = 1'b0;
         data_d  = data_q;
         null_d  = null_q;
      end
   end

   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= IDLE;
         slot_q  <= '0;
         pix_q   <= '0;
         acq_q   <= '0;
         wait_q  <= '0;
         pass_q  <= 1'b0;
         wr_en_q <= 1'b0;
         data_q  <= '0;
         null_q  <= '0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         pix_q   <= pix_d;
         acq_q   <= acq_d;
         wait_q  <= wait_d;
         pass_q  <= pass_d;
         wr_en_q <= wr_en_d;
         data_q  <= data_d;
         null_q  <= null_d;
      end
   end
endmodule

// File: tb/tb_sifh_frame_sequencer.sv
// tb_sifh_frame_sequencer: randomized frames against a slot-index reference model;
// expected words are queued by the driver and popped by an independent monitor.
module tb_sifh_frame_sequencer;
   localparam int PN = 4, DN = 4, AN = 8, NP = 16, TO = 15, GP = 4, TOTAL = PN*DN*AN;

   logic clk = 1'b0, res = 1'b0, start = 1'b0, abort = 1'b0;
   logic [PN-1:0]    src_valid = '0;
   logic [PN*NP-1:0] src_data = '0;
   logic [PN-1:0]    src_ready;
   logic             wr_en, pass, busy, frame_done;
   logic [NP-1:0]    data;
   logic [15:0]      null_cnt;

   sifh_frame_sequencer dut (
      .clk(clk), .res(res), .start(start), .abort(abort),
      .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
      .wr_en(wr_en), .data(data), .pass(pass), .busy(busy),
      .frame_done(frame_done), .null_cnt(null_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [NP-1:0] d; logic p; int c;} exp_t;
   exp_t q[$];

   int tests = 0, fails = 0;
   bit m_busy = 0, m_pass = 0, do_start = 0, do_abort = 0;
   int m_idx = 0, m_wait = 0, m_null = 0, m_feed_at = -1, exp_done = -1;
   int done_cnt = 0, pulses = 0, mode = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // one clock cycle: drive inputs, then advance the reference model on what was driven
   task automatic step();
      bit feeding, hs;
      int pix;
      @(posedge clk); #1;
      start = do_start;
      abort = do_abort;
      for (int p = 0; p < PN; p++) begin
         case (mode)
            1:       src_valid[p] = p != 2;
            2:       src_valid[p] = p == 3 ? $urandom_range(0, 7) == 0 : $urandom_range(0, 3) != 0;
            4:       src_valid[p] = m_wait == TO;
            default: src_valid[p] = 1'b1;
         endcase
         src_data[p*NP +: NP] = mode == 3 ? 16'(p*16'h1000 + cyc) : 16'($urandom);
      end
      if (m_busy && exp_done >= 0 && cyc > exp_done) m_busy = 0;
      feeding = m_busy && m_feed_at >= 0 && cyc >= m_feed_at;
      pix = (m_idx / DN) % PN;
      chk("src_ready", src_ready, feeding ? (1 << pix) : 0);
      chk("busy", busy, m_busy);
      if (abort) begin
         m_busy = 0;
         m_feed_at = -1;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_pass = 0; m_idx = 0; m_wait = 0; m_null = 0;
            m_feed_at = cyc + 1;
            exp_done = -1;
         end
      end else if (feeding) begin
         hs = src_valid[pix];
         if (hs || m_wait == TO) begin
            q.push_back('{hs ? src_data[pix*NP +: NP] : 16'hFFFF, m_pass, cyc + 1});
            if (!hs) m_null++;
            m_wait = 0;
            m_idx++;
            if (m_idx == TOTAL) begin
               m_idx = 0;
               if (!m_pass) begin
                  m_pass = 1;
                  m_feed_at = cyc + GP + 1;
               end else begin
                  m_feed_at = -1;
                  exp_done = cyc + 1;
               end
            end
         end else m_wait++;
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (res) begin
         if (wr_en) begin
            pulses++;
            if (q.size() == 0) chk("wr_en_unexpected", wr_en, 0);
            else begin
               e = q.pop_front();
               chk("data", data, e.d);
               chk("pass", pass, e.p);
               chk("wr_cycle", cyc, e.c);
            end
         end
         if (frame_done) begin
            done_cnt++;
            chk("done_cycle", cyc, exp_done);
            chk("null_at_done", null_cnt, m_null);
         end
      end
   end

   task automatic run_frame(int md, int start_mid, int exp_null);
      int d0 = done_cnt, guard = 0;
      mode = md;
      pulses = 0;
      do_start = 1; step(); do_start = 0;
      while (m_busy && guard < 20000) begin
         do_start = start_mid > 0 && guard == start_mid;
         step();
         guard++;
      end
      do_start = 0;
      if (guard >= 20000) begin
         tests++; fails++;
         $display("FAIL frame_timeout: mode %0d did not finish within budget", md);
      end
      repeat (3) step();
      chk("frame_done_count", done_cnt, d0 + 1);
      chk("pulses", pulses, 2*TOTAL);
      chk("queue_empty", q.size(), 0);
      chk("pass_hold", pass, 1);
      if (exp_null >= 0) chk("null_cnt", null_cnt, exp_null);
   endtask

   initial begin
      int d0, g;
      #12;
      chk("reset_outputs", {wr_en, data, pass, busy, frame_done, src_ready, null_cnt}, 0);
      res = 1'b1;
      repeat (2) step();
      run_frame(0, 0, 0);
      run_frame(1, 0, 64);
      run_frame(3, 0, 0);
      run_frame(2, 30, -1);
      // abort in cycle 50 of the coarse pass, with pixel 2 silent so null_cnt is non-zero
      mode = 1; d0 = done_cnt;
      do_start = 1; step(); do_start = 0;
      repeat (49) step();
      do_abort = 1; step(); do_abort = 0;
      step();
      chk("abort_wr_en", wr_en, 0);
      chk("abort_null_hold", null_cnt, m_null);
      chk("abort_pass", pass, 0);
      repeat (30) step();
      chk("abort_no_done", done_cnt, d0);
      chk("abort_queue", q.size(), 0);
      run_frame(0, 0, 0);
      // asynchronous reset in the middle of the fine pass
      mode = 2; g = 0;
      do_start = 1; step(); do_start = 0;
      while (!(m_pass && m_idx > 20) && g < 20000) begin step(); g++; end
      #2 res = 1'b0;
      #1 chk("midreset_outputs", {wr_en, data, pass, busy, frame_done, src_ready, null_cnt}, 0);
      q.delete();
      m_busy = 0; m_feed_at = -1; exp_done = -1; m_wait = 0;
      @(posedge clk); @(posedge clk); #3 res = 1'b1;
      repeat (20) step();
      chk("midreset_queue", q.size(), 0);
      run_frame(4, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
